// File: rtl/fir_mac_seq_if.sv
// Bundle of the sample, coefficient, ALU and output buses of fir_mac_seq.
// The slave modport is the filter's view; the master modport is the view of
// whatever drives samples and coefficients, models the ALU and consumes y[n].
interface fir_mac_seq_if #(
    parameter int TAPS = 8
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [15:0]   in_sample;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [15:0]   coef_data;
    logic [1:0]           alu_op_sel;
    logic signed [15:0]   alu_a;
    logic signed [15:0]   alu_b;
    logic signed [31:0]   alu_result;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [31:0]   out_data;

    modport slave (
        input  in_valid, in_sample, coef_we, coef_addr, coef_data,
        input  alu_result, out_ready,
        output in_ready, alu_op_sel, alu_a, alu_b, out_valid, out_data
    );

    modport master (
        output in_valid, in_sample, coef_we, coef_addr, coef_data,
        output alu_result, out_ready,
        input  in_ready, alu_op_sel, alu_a, alu_b, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one multiply per cycle issued to an external,
// one-cycle-latency ALU, products summed in an ACC_W-bit accumulator.
// Optional macro FIR_SAT_EN: clamp out_data to the signed 32-bit range
// instead of returning the accumulator's low 32 bits.
module fir_mac_seq #(
    parameter int TAPS  = 8,
    parameter int ACC_W = 40
) (
    input  logic           clk,
    input  logic           rst_n,
    fir_mac_seq_if.slave   bus
);
    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t                   r_state;
    logic [AW-1:0]            r_k;
    logic signed [15:0]       r_x [TAPS];
    logic signed [15:0]       r_c [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_pipe;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic signed [31:0]       r_out_data;
    logic [1:0]               r_alu_op;
    logic signed [15:0]       r_alu_a;
    logic signed [15:0]       r_alu_b;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic [AW-1:0]            w_k_inc;
    logic signed [15:0]       w_c0_eff;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [31:0]       w_out_fmt;

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.alu_op_sel = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;

    assign w_accept   = (r_state == IDLE) && bus.in_valid;
    assign w_coef_wr  = (r_state == IDLE) && bus.coef_we;
    assign w_k_inc    = r_k + 1'b1;
    // A coefficient write on the accepting edge must already be seen by tap 0.
    assign w_c0_eff   = (w_coef_wr && (bus.coef_addr == '0)) ? bus.coef_data : r_c[0];
    assign w_prod_ext = ACC_W'(bus.alu_result);
    // r_pipe marks that alu_result holds the product issued on the previous cycle.
    assign w_acc_next = r_pipe ? (r_acc + w_prod_ext) : r_acc;

`ifdef FIR_SAT_EN
    logic [ACC_W-32:0] w_upper;
    assign w_upper = w_acc_next[ACC_W-1:31];
    // Clamp when the bits above the 32-bit sign bit disagree with it.
    assign w_out_fmt = ((&w_upper) || !(|w_upper)) ? w_acc_next[31:0]
                     : (w_acc_next[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF);
`else
    assign w_out_fmt = w_acc_next[31:0];
`endif

    // Delay line shifts on accept; coefficients load only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_x[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_x[0] <= bus.in_sample;
                for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
            end
            for (int i = 0; i < TAPS; i++) begin
                if (w_coef_wr && (bus.coef_addr == i[AW-1:0])) r_c[i] <= bus.coef_data;
            end
        end
    end

    // Control FSM with registered ALU operands, accumulator and output port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_acc       <= '0;
            r_pipe      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_alu_op    <= 2'b00;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
        end else begin
            r_pipe <= (r_alu_op == 2'b01);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= MAC;
                        r_k        <= '0;
                        r_acc      <= '0;
                        r_in_ready <= 1'b0;
                        r_alu_op   <= 2'b01;
                        r_alu_a    <= bus.in_sample;
                        r_alu_b    <= w_c0_eff;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    if (r_k == AW'(TAPS - 1)) begin
                        r_state  <= DRAIN;
                        r_alu_op <= 2'b00;
                        r_alu_a  <= '0;
                        r_alu_b  <= '0;
                    end else begin
                        r_k     <= w_k_inc;
                        r_alu_a <= r_x[w_k_inc];
                        r_alu_b <= r_c[w_k_inc];
                    end
                end
                DRAIN: begin
                    r_acc       <= w_acc_next;
                    r_out_data  <= w_out_fmt;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq with a behavioural ALU, a reference FIR model
// and a queue of expected outputs.
module tb_fir_mac_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_seq_if #(.TAPS(8)) bus();

    fir_mac_seq #(.TAPS(8), .ACC_W(40)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External ALU: result registered one cycle after the operands.
    always @(posedge clk) begin
        int pa;
        int pb;
        pa = bus.alu_a;
        pb = bus.alu_b;
        bus.alu_result <= (bus.alu_op_sel == 2'b01) ? (pa * pb) : (pa + pb);
    end

    int checks = 0;
    int errors = 0;
    longint q[$];
    int m_x[8];
    int m_c[8];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_y();
        longint s;
        logic [63:0] v;
        s = 0;
        for (int i = 0; i < 8; i++) s += longint'(m_x[i]) * longint'(m_c[i]);
`ifdef FIR_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
        v = s;
        s = longint'($signed(v[31:0]));
`endif
        return s;
    endfunction

    task automatic wr_coef(input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a[2:0];
        bus.coef_data = d[15:0];
        @(posedge clk); #1;
        bus.coef_we = 1'b0;
        m_c[a] = d;
    endtask

    task automatic issue(input int s);
        bus.in_valid  = 1'b1;
        bus.in_sample = s[15:0];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 7; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = s;
        q.push_back(model_y());
        $display("issue sample=%0d expected_y=%0d", s, q[$]);
        chk("in_ready_after_accept", bus.in_ready, 0);
    endtask

    task automatic wait_out(input bit glitch, output logic signed [63:0] y);
        int n;
        bit seen;
        bit bad_ready;
        longint e;
        n = 0; seen = 0; bad_ready = 0; y = 0;
        chk("first_op", bus.alu_op_sel, 2'b01);
        chk("first_a", bus.alu_a, m_x[0]);
        chk("first_b", bus.alu_b, m_c[0]);
        while (!seen && n < 20) begin
            if (glitch) begin
                bus.coef_we   = 1'b1;
                bus.coef_addr = 3'd0;
                bus.coef_data = 16'sd77;
            end
            @(posedge clk); #1;
            n++;
            if (bus.out_valid) seen = 1;
            else if (bus.in_ready !== 1'b0) bad_ready = 1;
        end
        bus.coef_we = 1'b0;
        chk("in_ready_low_during_calc", bad_ready, 0);
        chk("latency", n, 9);
        if (q.size() > 0) e = q.pop_front(); else e = 0;
        y = bus.out_data;
        chk("out_data", y, e);
        $display("output y=%0d expected=%0d latency=%0d", y, e, n);
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_hs", bus.out_valid, 0);
        chk("in_ready_after_hs", bus.in_ready, 1);
    endtask

    initial begin
        logic signed [63:0] y;
        logic signed [63:0] held;
        bit spurious;
        bus.in_valid = 0; bus.in_sample = 0; bus.coef_we = 0; bus.coef_addr = 0;
        bus.coef_data = 0; bus.out_ready = 0; bus.alu_result = 0;
        for (int i = 0; i < 8; i++) begin m_x[i] = 0; m_c[i] = 0; end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_op", bus.alu_op_sel, 0);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_b", bus.alu_b, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse response with c = 1..8
        for (int i = 0; i < 8; i++) wr_coef(i, i + 1);
        for (int i = 0; i < 8; i++) begin
            issue((i == 0) ? 1 : 0);
            wait_out(0, y);
            chk("impulse_const", y, i + 1);
            handshake();
        end

        // Backpressure: output held, extra samples ignored
        issue(100);
        wait_out(0, y);
        held = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_sample = 16'sd999;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_stable", bus.out_data, held);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        handshake();
        issue(-3);
        wait_out(0, y);
        handshake();

        // Coefficient lock during MAC
        wr_coef(0, 5);
        issue(2);
        wait_out(1, y);
        handshake();
        issue(1);
        wait_out(0, y);
        handshake();

        // Reset in the middle of MAC (k = 3)
        issue(9);
        void'(q.pop_back());
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_op", bus.alu_op_sel, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin m_x[i] = 0; m_c[i] = 0; end
        spurious = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) spurious = 1;
        end
        chk("midrst_no_output", spurious, 0);
        wr_coef(0, 3);
        issue(7);
        wait_out(0, y);
        chk("midrst_result", y, 21);
        handshake();

        // Overflow
        for (int i = 0; i < 8; i++) wr_coef(i, 32767);
        for (int i = 0; i < 8; i++) begin
            issue(32767);
            wait_out(0, y);
            handshake();
        end
`ifdef FIR_SAT_EN
        chk("overflow_const", y, 64'sd2147483647);
`else
        chk("overflow_const", y, -64'sd524280);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
